// File: rtl/mag_packet_checker_if.sv
// ---------------------------------------------------------------------------
// mag_packet_checker_if
// Bundles the magnetometer packet bus and the checker's telemetry outputs.
//
// Signals:
//   MAG_DATA     80  packet {z[79:64], y[63:48], x[47:32], ts[31:8], id[7:0]}
//   X_OUT/Y_OUT/Z_OUT 16  last good axis values
//   TS_OUT       24  last good timestamp
//   VALID         1  one-cycle pulse: packet good and link (still) locked
//   LOCKED        1  link is LOCKED or HOLD
//   STATE         2  00 IDLE, 01 ACQUIRE, 10 LOCKED, 11 HOLD
//   *_ERR_CNT     8  saturating per-class error counters
//   GOOD_CNT     16  wrapping good-packet counter
//
// Handshake: there is none. MAG_DATA is sampled unconditionally on every
// CLK_10HZ rising edge; VALID is a strobe with no ready/back-pressure, and a
// consumer must take X/Y/Z/TS_OUT in the cycle VALID is high.
//
// Modports: master = packet source / observer, slave = the checker.
// ---------------------------------------------------------------------------
interface mag_packet_checker_if;
  logic [79:0] MAG_DATA;
  logic [15:0] X_OUT;
  logic [15:0] Y_OUT;
  logic [15:0] Z_OUT;
  logic [23:0] TS_OUT;
  logic        VALID;
  logic        LOCKED;
  logic [1:0]  STATE;
  logic [7:0]  ID_ERR_CNT;
  logic [7:0]  FMT_ERR_CNT;
  logic [7:0]  SEQ_ERR_CNT;
  logic [7:0]  TS_ERR_CNT;
  logic [15:0] GOOD_CNT;

  modport master (
    output MAG_DATA,
    input  X_OUT, Y_OUT, Z_OUT, TS_OUT, VALID, LOCKED, STATE,
    input  ID_ERR_CNT, FMT_ERR_CNT, SEQ_ERR_CNT, TS_ERR_CNT, GOOD_CNT
  );

  modport slave (
    input  MAG_DATA,
    output X_OUT, Y_OUT, Z_OUT, TS_OUT, VALID, LOCKED, STATE,
    output ID_ERR_CNT, FMT_ERR_CNT, SEQ_ERR_CNT, TS_ERR_CNT, GOOD_CNT
  );
endinterface

// File: rtl/mag_packet_checker.sv
// ---------------------------------------------------------------------------
// mag_packet_checker
// Receive-side checker for the 80-bit magnetometer packet. Every CLK_10HZ
// edge the packet is classified (NODATA / ID / FMT / SEQ / TS / GOOD),
// link lock is tracked by a four-state machine, good packets are republished
// and per-class saturating error counters are kept for telemetry.
//
// Ports:
//   CLK_10HZ  in   sample clock, rising edge
//   RESET     in   asynchronous, active-low
//   mag_bus   slave modport of mag_packet_checker_if (packet in, results out)
//
// Latency: one edge. Outputs and STATE reflect the packet sampled at the
// most recent rising edge.
// ---------------------------------------------------------------------------
module mag_packet_checker #(
  parameter logic [7:0]  ID_BYTE     = 8'h4D,
  parameter logic [15:0] Y_OFFSET    = 16'd50,
  parameter logic [15:0] Z_OFFSET    = 16'd100,
  parameter logic [23:0] MAX_TS_STEP = 24'd16,
  parameter int          LOCK_COUNT  = 4,
  parameter int          LOSS_COUNT  = 3
) (
  input logic                 CLK_10HZ,
  input logic                 RESET,
  mag_packet_checker_if.slave mag_bus
);

  localparam logic [2:0] LP_LOCK = 3'(LOCK_COUNT);
  localparam logic [2:0] LP_LOSS = 3'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10,
    ST_HOLD    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    CL_NODATA = 3'd0,
    CL_ID     = 3'd1,
    CL_FMT    = 3'd2,
    CL_SEQ    = 3'd3,
    CL_TS     = 3'd4,
    CL_GOOD   = 3'd5
  } class_t;

  // State / history registers
  state_t      r_state;
  logic [2:0]  r_good_run;
  logic [2:0]  r_bad_run;
  logic [15:0] r_prev_x;
  logic [23:0] r_prev_ts;
  logic        r_prev_valid;

  // Output registers
  logic [15:0] r_x_out;
  logic [15:0] r_y_out;
  logic [15:0] r_z_out;
  logic [23:0] r_ts_out;
  logic        r_valid;
  logic [7:0]  r_id_cnt;
  logic [7:0]  r_fmt_cnt;
  logic [7:0]  r_seq_cnt;
  logic [7:0]  r_ts_cnt;
  logic [15:0] r_good_cnt;

  // Packet fields
  logic [15:0] w_z;
  logic [15:0] w_y;
  logic [15:0] w_x;
  logic [23:0] w_ts;
  logic [7:0]  w_id;
  logic [15:0] w_y_diff;
  logic [15:0] w_z_diff;
  logic [15:0] w_x_expect;
  logic [23:0] w_ts_step;

  assign w_z        = mag_bus.MAG_DATA[79:64];
  assign w_y        = mag_bus.MAG_DATA[63:48];
  assign w_x        = mag_bus.MAG_DATA[47:32];
  assign w_ts       = mag_bus.MAG_DATA[31:8];
  assign w_id       = mag_bus.MAG_DATA[7:0];
  // All differences are modular so x/ts wrap-around stays legal.
  assign w_y_diff   = w_y - w_x;
  assign w_z_diff   = w_z - w_x;
  assign w_x_expect = r_prev_x + 16'd1;
  assign w_ts_step  = w_ts - r_prev_ts;

  // ---------------------------------------------------------------------
  // Classification, highest priority first. SEQ and TS only apply once a
  // previous packet has been recorded.
  // ---------------------------------------------------------------------
  class_t w_class;
  logic   w_good;
  logic   w_nodata;

  always_comb begin
    w_class = CL_GOOD;
    if (mag_bus.MAG_DATA == 80'h0) begin
      w_class = CL_NODATA;
    end else if (w_id != ID_BYTE) begin
      w_class = CL_ID;
    end else if ((w_y_diff != Y_OFFSET) || (w_z_diff != Z_OFFSET)) begin
      w_class = CL_FMT;
    end else if (r_prev_valid && (w_x != w_x_expect)) begin
      w_class = CL_SEQ;
    end else if (r_prev_valid &&
                 ((w_ts_step == 24'd0) || (w_ts_step > MAX_TS_STEP))) begin
      w_class = CL_TS;
    end
  end

  assign w_good   = (w_class == CL_GOOD);
  assign w_nodata = (w_class == CL_NODATA);

  // ---------------------------------------------------------------------
  // Lock FSM: next state and run counters
  // ---------------------------------------------------------------------
  state_t     w_state_nxt;
  logic [2:0] w_good_run_nxt;
  logic [2:0] w_bad_run_nxt;
  logic [2:0] w_good_run_inc;
  logic [2:0] w_bad_run_inc;

  assign w_good_run_inc = r_good_run + 3'd1;
  assign w_bad_run_inc  = r_bad_run + 3'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;

    if (w_nodata) begin
      w_state_nxt    = ST_IDLE;
      w_good_run_nxt = 3'd0;
      w_bad_run_nxt  = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_good) begin
            w_good_run_nxt = 3'd1;
            w_state_nxt    = (LP_LOCK == 3'd1) ? ST_LOCKED : ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (w_good) begin
            w_good_run_nxt = w_good_run_inc;
            if (w_good_run_inc == LP_LOCK) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_good_run_nxt = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            if (LP_LOSS == 3'd1) begin
              w_state_nxt    = ST_ACQUIRE;
              w_good_run_nxt = 3'd0;
              w_bad_run_nxt  = 3'd0;
            end else begin
              w_state_nxt   = ST_HOLD;
              w_bad_run_nxt = 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (w_good) begin
            w_state_nxt   = ST_LOCKED;
            w_bad_run_nxt = 3'd0;
          end else if (w_bad_run_inc == LP_LOSS) begin
            w_state_nxt    = ST_ACQUIRE;
            w_good_run_nxt = 3'd0;
            w_bad_run_nxt  = 3'd0;
          end else begin
            w_bad_run_nxt = w_bad_run_inc;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_good_run_nxt = 3'd0;
          w_bad_run_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_good_run <= 3'd0;
      r_bad_run  <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_run <= w_good_run_nxt;
      r_bad_run  <= w_bad_run_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // History, published fields and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      r_prev_x     <= 16'd0;
      r_prev_ts    <= 24'd0;
      r_prev_valid <= 1'b0;
      r_x_out      <= 16'd0;
      r_y_out      <= 16'd0;
      r_z_out      <= 16'd0;
      r_ts_out     <= 24'd0;
      r_valid      <= 1'b0;
      r_id_cnt     <= 8'd0;
      r_fmt_cnt    <= 8'd0;
      r_seq_cnt    <= 8'd0;
      r_ts_cnt     <= 8'd0;
      r_good_cnt   <= 16'd0;
    end else begin
      // SEQ/TS packets also reload history so the checker resyncs onto a
      // restarted stream instead of flagging every later packet.
      case (w_class)
        CL_GOOD, CL_SEQ, CL_TS: begin
          r_prev_x     <= w_x;
          r_prev_ts    <= w_ts;
          r_prev_valid <= 1'b1;
        end
        CL_NODATA: begin
          r_prev_x     <= 16'd0;
          r_prev_ts    <= 24'd0;
          r_prev_valid <= 1'b0;
        end
        default: ;
      endcase

      if (w_good) begin
        r_x_out    <= w_x;
        r_y_out    <= w_y;
        r_z_out    <= w_z;
        r_ts_out   <= w_ts;
        r_good_cnt <= r_good_cnt + 16'd1;
      end

      r_valid <= w_good && (w_state_nxt == ST_LOCKED);

      if ((w_class == CL_ID) && (r_id_cnt != 8'hFF)) begin
        r_id_cnt <= r_id_cnt + 8'd1;
      end
      if ((w_class == CL_FMT) && (r_fmt_cnt != 8'hFF)) begin
        r_fmt_cnt <= r_fmt_cnt + 8'd1;
      end
      if ((w_class == CL_SEQ) && (r_seq_cnt != 8'hFF)) begin
        r_seq_cnt <= r_seq_cnt + 8'd1;
      end
      if ((w_class == CL_TS) && (r_ts_cnt != 8'hFF)) begin
        r_ts_cnt <= r_ts_cnt + 8'd1;
      end
    end
  end

  assign mag_bus.X_OUT       = r_x_out;
  assign mag_bus.Y_OUT       = r_y_out;
  assign mag_bus.Z_OUT       = r_z_out;
  assign mag_bus.TS_OUT      = r_ts_out;
  assign mag_bus.VALID       = r_valid;
  assign mag_bus.LOCKED      = (r_state == ST_LOCKED) || (r_state == ST_HOLD);
  assign mag_bus.STATE       = r_state;
  assign mag_bus.ID_ERR_CNT  = r_id_cnt;
  assign mag_bus.FMT_ERR_CNT = r_fmt_cnt;
  assign mag_bus.SEQ_ERR_CNT = r_seq_cnt;
  assign mag_bus.TS_ERR_CNT  = r_ts_cnt;
  assign mag_bus.GOOD_CNT    = r_good_cnt;

endmodule
